fwd_hazard_controller: RTL

Pipeline hazard and forwarding controller for the ARM five-stage core. It tracks the destination register of every instruction in the EXE, MEM and WB stages. It raises a stall request for the ID stage on unresolvable read-after-write (RAW) dependencies. It produces the registered forwarding-mux selects consumed by the execute stage's two source multiplexers. It sits beside the ID/EXE pipeline register and advances in lock-step with the pipeline.

---
 rtl/fwd_hazard_controller_if.sv | 47 ++++
 rtl/fwd_hazard_controller.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fwd_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_controller_if
// Description : ID-stage bus between the decode stage and the hazard /
//               forwarding controller.
//               master : decode side, drives the ID instruction fields and
//                        the pipeline-wide freeze/flush controls, receives
//                        the stall request and the EXE forwarding selects.
//               slave  : controller side.
//   srcRn/srcRm   : source registers of the ID instruction
//   useRn/twoSrc  : source-use flags for srcRn / srcRm
//   destID        : destination register of the ID instruction
//   wbEnID        : ID instruction writes back
//   memReadID     : ID instruction is a load
//   freeze        : pipeline-wide hold
//   flush         : kill the instruction in ID
//   hazard        : combinational stall request for ID
//   selSrc1/2     : registered EXE forwarding-mux selects
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_hazard_controller_if;
   logic [3:0] srcRn;
   logic [3:0] srcRm;
   logic       useRn;
   logic       twoSrc;
   logic [3:0] destID;
   logic       wbEnID;
   logic       memReadID;
   logic       freeze;
   logic       flush;
   logic       hazard;
   logic [1:0] selSrc1;
   logic [1:0] selSrc2;

   modport master (
      output srcRn, srcRm, useRn, twoSrc, destID, wbEnID, memReadID,
             freeze, flush,
      input  hazard, selSrc1, selSrc2
   );

   modport slave (
      input  srcRn, srcRm, useRn, twoSrc, destID, wbEnID, memReadID,
             freeze, flush,
      output hazard, selSrc1, selSrc2
   );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_controller
// Description : Hazard detection and operand-forwarding control for the
//               five-stage ARM pipeline. Tracks the destination of the
//               instructions in EXE, MEM and WB, raises a combinational stall
//               for unresolvable RAW dependencies and registers the forwarding
//               selects for the execute stage's two source muxes.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous reset, active-high
//               i_bus - ID-stage bus (slave side), see fwd_hazard_controller_if
// Parameters  : FORWARD_EN - 1 forwards ALU results, 0 stalls every in-flight RAW
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_controller #(
   parameter int unsigned FORWARD_EN = 1
) (
   input  wire logic              clk,
   input  wire logic              rst,
   fwd_hazard_controller_if.slave i_bus
);

   localparam logic [1:0] c_SEL_RF  = 2'd0;  // register-file operand
   localparam logic [1:0] c_SEL_MEM = 2'd1;  // ALU result now in MEM
   localparam logic [1:0] c_SEL_WB  = 2'd2;  // value now in WB

   // Stage records
   logic [3:0] r_exe_dest;
   logic       r_exe_wb;
   logic       r_exe_mr;
   logic [3:0] r_mem_dest;
   logic       r_mem_wb;
   logic       r_mem_mr;
   logic [3:0] r_wb_dest;
   logic       r_wb_wb;

   logic [1:0] r_sel1;
   logic [1:0] r_sel2;

   logic       w_rn_e;
   logic       w_rn_m;
   logic       w_rm_e;
   logic       w_rm_m;
   logic       w_hazard;
   logic [1:0] w_nsel1;
   logic [1:0] w_nsel2;
   logic       w_kill;

   // Matches are qualified by the use flag, so an unused source field never
   // stalls or forwards. Bubbles carry wbEn=0 and therefore never match.
   assign w_rn_e = i_bus.useRn  && r_exe_wb && (r_exe_dest == i_bus.srcRn);
   assign w_rn_m = i_bus.useRn  && r_mem_wb && (r_mem_dest == i_bus.srcRn);
   assign w_rm_e = i_bus.twoSrc && r_exe_wb && (r_exe_dest == i_bus.srcRm);
   assign w_rm_m = i_bus.twoSrc && r_mem_wb && (r_mem_dest == i_bus.srcRm);

   generate
      if (FORWARD_EN != 0) begin : g_fwd
         // Only a load in EXE cannot be forwarded in time (load-use).
         assign w_hazard = r_exe_mr && (w_rn_e || w_rm_e);
         // EXE is the youngest producer, so it wins over MEM.
         assign w_nsel1  = (w_rn_e && !r_exe_mr) ? c_SEL_MEM :
                           w_rn_m                ? c_SEL_WB  : c_SEL_RF;
         assign w_nsel2  = (w_rm_e && !r_exe_mr) ? c_SEL_MEM :
                           w_rm_m                ? c_SEL_WB  : c_SEL_RF;
      end else begin : g_nofwd
         // Without forwarding, wait until the producer reaches WB, where the
         // first-half-cycle register-file write makes the value visible.
         assign w_hazard = w_rn_e || w_rn_m || w_rm_e || w_rm_m;
         assign w_nsel1  = c_SEL_RF;
         assign w_nsel2  = c_SEL_RF;
      end
   endgenerate

   assign w_kill = w_hazard || i_bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_exe_dest <= 4'd0;
         r_exe_wb   <= 1'b0;
         r_exe_mr   <= 1'b0;
         r_mem_dest <= 4'd0;
         r_mem_wb   <= 1'b0;
         r_mem_mr   <= 1'b0;
         r_wb_dest  <= 4'd0;
         r_wb_wb    <= 1'b0;
         r_sel1     <= c_SEL_RF;
         r_sel2     <= c_SEL_RF;
      end else if (!i_bus.freeze) begin
         r_wb_dest  <= r_mem_dest;
         r_wb_wb    <= r_mem_wb;
         r_mem_dest <= r_exe_dest;
         r_mem_wb   <= r_exe_wb;
         r_mem_mr   <= r_exe_mr;
         if (w_kill) begin
            // Stall and flush share one bubble, so coinciding events insert
            // only a single bubble.
            r_exe_dest <= 4'd0;
            r_exe_wb   <= 1'b0;
            r_exe_mr   <= 1'b0;
            r_sel1     <= c_SEL_RF;
            r_sel2     <= c_SEL_RF;
         end else begin
            r_exe_dest <= i_bus.destID;
            r_exe_wb   <= i_bus.wbEnID;
            r_exe_mr   <= i_bus.memReadID;
            r_sel1     <= w_nsel1;
            r_sel2     <= w_nsel2;
         end
      end
   end

   assign i_bus.hazard  = w_hazard;
   assign i_bus.selSrc1 = r_sel1;
   assign i_bus.selSrc2 = r_sel2;

   // The WB record and MEM.memRead document pipeline occupancy but feed no
   // decision here (WB producers are covered by the register-file timing).
   logic w_unused;
   assign w_unused = ^{r_wb_dest, r_wb_wb, r_mem_mr, r_exe_mr};

endmodule
`default_nettype wire
